// File: rtl/joy_db9md_pkg.sv
// joy_db9md_pkg: shared button/pin indices and pin-group type for the Mega Drive pad interface.
package joy_db9md_pkg;
    localparam int BTN_R     = 0;
    localparam int BTN_L     = 1;
    localparam int BTN_D     = 2;
    localparam int BTN_U     = 3;
    localparam int BTN_B     = 4;
    localparam int BTN_C     = 5;
    localparam int BTN_A     = 6;
    localparam int BTN_START = 7;
    localparam int BTN_MODE  = 8;
    localparam int BTN_X     = 9;
    localparam int BTN_Y     = 10;
    localparam int BTN_Z     = 11;
    localparam int PIN_UP = 0;
    localparam int PIN_DN = 1;
    localparam int PIN_LF = 2;
    localparam int PIN_RT = 3;
    localparam int PIN_BA = 4;
    localparam int PIN_CS = 5;
    typedef logic [5:0] db9md_pins_t;
endpackage

// File: rtl/joy_db9md_pad_sync2.sv
// sync2: two-flop synchronizer with a configurable reset value.
module sync2 #(
    parameter logic RESET_VAL = 1'b1
) (
    input  logic clk,
    input  logic reset_n,
    input  logic d,
    output logic q
);
    logic meta;
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) {q, meta} <= {RESET_VAL, RESET_VAL};
        else          {q, meta} <= {meta, d};
    end
endmodule

// File: rtl/joy_db9md_pad.sv
// joy_db9md_pad: Mega Drive 3/6-button pad responder driven by the host select line.
module joy_db9md_pad
    import joy_db9md_pkg::*;
#(
    parameter int CLK_HZ     = 40000000,
    parameter int TIMEOUT_US = 1500,
    parameter int SIX_BUTTON = 1
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        select,
    input  logic [11:0] buttons,
    output db9md_pins_t pad_out,
    output logic [1:0]  phase
);
    localparam int TIMEOUT = (CLK_HZ / 1000000) * TIMEOUT_US;
    localparam int TW      = $clog2(TIMEOUT + 1);
    logic          sel_s, sel_prev, armed, six_en, rise, sel_edge, expired;
    logic [TW-1:0] timer;
    logic [1:0]    n_next;
    db9md_pins_t   pins;
    sync2 #(.RESET_VAL(1'b1)) u_sync (.clk(clk), .reset_n(reset_n), .d(select), .q(sel_s));
    assign rise     = sel_s & ~sel_prev;
    assign sel_edge = sel_s ^ sel_prev;
    assign expired  = timer == TW'(TIMEOUT);
    // Expiry zeroes n first so a coincident rising edge lands on phase 1.
    always_comb begin
        n_next = expired ? 2'd0 : phase;
        if (rise) n_next = n_next + 2'd1;
        if (!six_en) n_next = 2'd0;
        pins = '0;
        if (sel_s) begin
            pins[PIN_CS] = buttons[BTN_C];
            pins[PIN_BA] = buttons[BTN_B];
            pins[PIN_RT] = (n_next == 2'd3) ? buttons[BTN_MODE] : buttons[BTN_R];
            pins[PIN_LF] = (n_next == 2'd3) ? buttons[BTN_X]    : buttons[BTN_L];
            pins[PIN_DN] = (n_next == 2'd3) ? buttons[BTN_Y]    : buttons[BTN_D];
            pins[PIN_UP] = (n_next == 2'd3) ? buttons[BTN_Z]    : buttons[BTN_U];
        end else begin
            pins[PIN_CS] = buttons[BTN_START];
            pins[PIN_BA] = buttons[BTN_A];
            pins[PIN_RT] = n_next != 2'd3;
            pins[PIN_LF] = n_next != 2'd3;
            pins[PIN_DN] = (n_next == 2'd2) | ((n_next < 2'd2) & buttons[BTN_D]);
            pins[PIN_UP] = (n_next == 2'd2) | ((n_next < 2'd2) & buttons[BTN_U]);
        end
    end
    // Mode held at the first clock after reset locks the pad into 3-button mode.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sel_prev <= 1'b1;
            armed    <= 1'b0;
            six_en   <= SIX_BUTTON != 0;
            timer    <= '0;
            phase    <= 2'd0;
            pad_out  <= 6'h3F;
        end else begin
            sel_prev <= sel_s;
            armed    <= 1'b1;
            if (!armed) six_en <= (SIX_BUTTON != 0) & ~buttons[BTN_MODE];
            timer    <= sel_edge ? '0 : expired ? timer : timer + TW'(1);
            phase    <= n_next;
            pad_out  <= ~pins;
        end
    end
endmodule

// File: tb/tb_joy_db9md_pad.sv
// tb_joy_db9md_pad: directed checks of the pad responder's phase sequence, pin groups and timeout.
module tb_joy_db9md_pad;
    localparam int TIMEOUT = 40 * 50;
    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        select = 1'b1;
    logic [11:0] buttons = 12'h000;
    logic [5:0]  pad_out;
    logic [1:0]  phase;
    int          vectors = 0;
    int          miscompares = 0;

    joy_db9md_pad #(.CLK_HZ(40000000), .TIMEOUT_US(50), .SIX_BUTTON(1)) dut (
        .clk(clk), .reset_n(reset_n), .select(select), .buttons(buttons),
        .pad_out(pad_out), .phase(phase)
    );

    always #5 clk = ~clk;

    task automatic tick(input int k);
        repeat (k) @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [5:0] obs, input logic [5:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic pair();
        select = 1'b0;
        tick(40);
        select = 1'b1;
        tick(40);
    endtask

    initial begin
        logic [5:0] exp_lo [4] = '{6'h33, 6'h33, 6'h30, 6'h3F};
        logic [5:0] exp_hi [4] = '{6'h3F, 6'h3F, 6'h3A, 6'h3F};
        logic [1:0] exp_ph [4] = '{2'd1, 2'd2, 2'd3, 2'd0};
        tick(3);
        chk("reset_pad", pad_out, 6'h3F);
        chk("reset_phase", {4'b0, phase}, 6'd0);
        reset_n = 1'b1;
        tick(5);
        chk("idle_pad", pad_out, 6'h3F);
        tick(TIMEOUT + 10);
        chk("idle_long_phase", {4'b0, phase}, 6'd0);
        chk("idle_long_pad", pad_out, 6'h3F);
        buttons = 12'h048;
        tick(1);
        chk("ua_high", pad_out, 6'h3E);
        select = 1'b0;
        tick(2);
        chk("ua_low_early", pad_out, 6'h3E);
        tick(1);
        chk("ua_low_lat3", pad_out, 6'h22);
        tick(37);
        select = 1'b1;
        tick(40);
        chk("ua_phase1", {4'b0, phase}, 6'd1);
        tick(TIMEOUT + 10);
        chk("ua_timeout_phase", {4'b0, phase}, 6'd0);
        buttons = 12'hA00;
        for (int i = 0; i < 4; i++) begin
            select = 1'b0;
            tick(40);
            chk($sformatf("seq_low%0d", i), pad_out, exp_lo[i]);
            select = 1'b1;
            tick(40);
            chk($sformatf("seq_phase%0d", i), {4'b0, phase}, {4'b0, exp_ph[i]});
            chk($sformatf("seq_high%0d", i), pad_out, exp_hi[i]);
        end
        buttons = 12'h000;
        repeat (3) pair();
        chk("to_phase3", {4'b0, phase}, 6'd3);
        tick(TIMEOUT / 2);
        chk("to_half_phase", {4'b0, phase}, 6'd3);
        tick(TIMEOUT);
        chk("to_expired_phase", {4'b0, phase}, 6'd0);
        pair();
        chk("to_next_phase", {4'b0, phase}, 6'd1);
        select = 1'b0;
        tick(40);
        chk("to_next_low", pad_out, 6'h33);
        select = 1'b1;
        reset_n = 1'b0;
        buttons = 12'h100;
        tick(2);
        reset_n = 1'b1;
        tick(5);
        for (int i = 0; i < 4; i++) begin
            select = 1'b0;
            tick(40);
            chk($sformatf("mode_low%0d", i), pad_out, 6'h33);
            select = 1'b1;
            tick(40);
            chk($sformatf("mode_phase%0d", i), {4'b0, phase}, 6'd0);
            chk($sformatf("mode_high%0d", i), pad_out, 6'h3F);
        end
        reset_n = 1'b0;
        buttons = 12'hA00;
        tick(2);
        reset_n = 1'b1;
        tick(5);
        repeat (3) pair();
        chk("rst_pre_phase", {4'b0, phase}, 6'd3);
        chk("rst_pre_pad", pad_out, 6'h3A);
        #2;
        reset_n = 1'b0;
        #1;
        chk("rst_async_pad", pad_out, 6'h3F);
        chk("rst_async_phase", {4'b0, phase}, 6'd0);
        tick(2);
        reset_n = 1'b1;
        tick(5);
        pair();
        chk("rst_first_rise", {4'b0, phase}, 6'd1);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
